// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared types and default sizing for the scoreboarded register file.
//   clr_state_t  : states of the sequential clear engine
//   DATA_W_DEF   : default register / data-port width
//   NUM_REGS_DEF : default register count (power of two, >= 2)
// -----------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic [0:0] {
      CLR_IDLE  = 1'b0,
      CLR_SWEEP = 1'b1
   } clr_state_t;

   localparam int DATA_W_DEF   = 16;
   localparam int NUM_REGS_DEF = 8;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// -----------------------------------------------------------------------------
// regfile_rdport
// One combinational read port: selects a register word and its pending bit,
// and optionally forwards a write accepted in the current cycle.
// Ports:
//   rf_flat  in  all register words, word i at [i*DATA_W +: DATA_W]
//   pend_vec in  stored pending bits, one per register
//   sel      in  read index
//   wr_en    in  a write is accepted this cycle
//   wr_addr  in  index being written
//   wr_data  in  data being written
//   set_en   in  a pending-set is accepted this cycle
//   set_addr in  index being marked pending
//   rd_data  out read data (after bypass)
//   rd_pend  out pending bit (after bypass)
// -----------------------------------------------------------------------------
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int BYPASS   = 1
) (
   input  logic [NUM_REGS*DATA_W-1:0] rf_flat,
   input  logic [NUM_REGS-1:0]        pend_vec,
   input  logic [ADDR_W-1:0]          sel,
   input  logic                       wr_en,
   input  logic [ADDR_W-1:0]          wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       set_en,
   input  logic [ADDR_W-1:0]          set_addr,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_pend
);

   logic [DATA_W-1:0] rf_word [NUM_REGS];

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_unpack
      assign rf_word[gi] = rf_flat[gi*DATA_W +: DATA_W];
   end

   always_comb begin
      rd_data = rf_word[sel];
      rd_pend = pend_vec[sel];
      if ((BYPASS != 0) && wr_en && (wr_addr == sel)) begin
         rd_data = wr_data;
         // A producer being registered for this same index in this cycle
         // takes precedence over the write, so the pending bit is not masked.
         if (!(set_en && (set_addr == sel))) begin
            rd_pend = 1'b0;
         end
      end
   end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// NUM_REGS x DATA_W register file with one write port, two combinational read
// ports with optional write-to-read bypass, a per-register pending scoreboard
// and a sequential clear engine zeroing one register per cycle.
// NUM_REGS must be a power of two and at least 2; ADDR_W is derived.
// Ports:
//   Clk        in  clock, rising edge
//   Reset      in  asynchronous active-low reset
//   LD_REG     in  write request (dropped while Wr_ready=0)
//   DR         in  write index
//   Data       in  write data
//   Wr_ready   out write port can accept (low during a clear sweep)
//   SR1, SR2   in  read indices
//   SR1_out    out read data, port 1
//   SR2_out    out read data, port 2
//   SR1_pend   out pending bit, port 1
//   SR2_pend   out pending bit, port 2
//   Set_pend   in  mark Pend_addr pending (ignored during a sweep)
//   Pend_addr  in  scoreboard set index
//   Clr_start  in  start a clear sweep (single-cycle pulse, ignored if busy)
//   Clr_busy   out clear sweep in progress
// -----------------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int ADDR_W   = $clog2(NUM_REGS),
   parameter int BYPASS   = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              LD_REG,
   input  logic [ADDR_W-1:0] DR,
   input  logic [DATA_W-1:0] Data,
   output logic              Wr_ready,
   input  logic [ADDR_W-1:0] SR1,
   input  logic [ADDR_W-1:0] SR2,
   output logic [DATA_W-1:0] SR1_out,
   output logic [DATA_W-1:0] SR2_out,
   output logic              SR1_pend,
   output logic              SR2_pend,
   input  logic              Set_pend,
   input  logic [ADDR_W-1:0] Pend_addr,
   input  logic              Clr_start,
   output logic              Clr_busy
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   clr_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] idx_reg, idx_next;

   logic                       wr_accept;
   logic                       set_accept;
   logic [NUM_REGS*DATA_W-1:0] rf_flat;
   logic [NUM_REGS-1:0]        pend_vec;

   assign Clr_busy   = (state_reg == CLR_SWEEP);
   assign Wr_ready   = !Clr_busy;
   assign wr_accept  = LD_REG && Wr_ready;
   assign set_accept = Set_pend && !Clr_busy;

   // ---------------------------------------------------------------- clear FSM
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_reg <= CLR_IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      case (state_reg)
         CLR_IDLE: begin
            if (Clr_start) begin
               state_next = CLR_SWEEP;
               idx_next   = '0;
            end
         end
         CLR_SWEEP: begin
            // Exit on the last index so idx never wraps while sweeping.
            if (idx_reg == LAST_IDX) begin
               state_next = CLR_IDLE;
               idx_next   = '0;
            end else begin
               idx_next = idx_reg + ADDR_W'(1);
            end
         end
         default: begin
            state_next = CLR_IDLE;
            idx_next   = '0;
         end
      endcase
   end

   // ------------------------------------------------ storage and scoreboard
   // Writes and pending-sets are blocked during a sweep, so the sweep clear
   // never competes with them; within normal operation a pending-set beats
   // the write's pending clear on the same index.
   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] word_reg;
      logic              pend_reg;
      logic              sweep_hit;
      logic              wr_hit;
      logic              set_hit;

      assign sweep_hit = Clr_busy && (idx_reg == ADDR_W'(gi));
      assign wr_hit    = wr_accept && (DR == ADDR_W'(gi));
      assign set_hit   = set_accept && (Pend_addr == ADDR_W'(gi));

      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            word_reg <= '0;
            pend_reg <= 1'b0;
         end else if (sweep_hit) begin
            word_reg <= '0;
            pend_reg <= 1'b0;
         end else begin
            if (wr_hit) begin
               word_reg <= Data;
            end
            if (set_hit) begin
               pend_reg <= 1'b1;
            end else if (wr_hit) begin
               pend_reg <= 1'b0;
            end
         end
      end

      assign rf_flat[gi*DATA_W +: DATA_W] = word_reg;
      assign pend_vec[gi]                 = pend_reg;
   end

   // ---------------------------------------------------------- read ports
   regfile_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS)
   ) u_rd1 (
      .rf_flat  (rf_flat),
      .pend_vec (pend_vec),
      .sel      (SR1),
      .wr_en    (wr_accept),
      .wr_addr  (DR),
      .wr_data  (Data),
      .set_en   (set_accept),
      .set_addr (Pend_addr),
      .rd_data  (SR1_out),
      .rd_pend  (SR1_pend)
   );

   regfile_rdport #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS)
   ) u_rd2 (
      .rf_flat  (rf_flat),
      .pend_vec (pend_vec),
      .sel      (SR2),
      .wr_en    (wr_accept),
      .wr_addr  (DR),
      .wr_data  (Data),
      .set_en   (set_accept),
      .set_addr (Pend_addr),
      .rd_data  (SR2_out),
      .rd_pend  (SR2_pend)
   );

endmodule : regfile_sb
